// File: rtl/gpp16_bus_pkg.sv
// Shared types and helpers for the GPP16 memory-port arbiter.
// Read tags carry the issuing master id through the memory latency.
package gpp16_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Wide enough for any master count the arbiter is built with.
    localparam int TAG_IDW = 8;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } rd_tag_t;

    // Index width for n items, never less than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        for (int v = 2; v < n; v = v * 2) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/gpp16_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping,
// with an optional override that always hands master 0 the win.
module gpp16_rr_pick
    import gpp16_bus_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          cpu_prio,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        if (cpu_prio && req[0]) begin
            gnt[0] = 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                cand = IW'((int'(ptr) + i) % N);
                if (!found && req[cand]) begin
                    found     = 1'b1;
                    gnt[cand] = 1'b1;
                    idx       = cand;
                end
            end
        end
    end

endmodule

// File: rtl/gpp16_mem_arbiter.sv
// Shares the single GPP16 memory port among N masters (master 0 = core).
// Grant FSM, burst hold counter, owner mux and read-id return pipeline.
module gpp16_mem_arbiter
    import gpp16_bus_pkg::*;
#(
    parameter int N        = 4,
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int RD_LAT   = 1,
    parameter int MAX_HOLD = 8,
    parameter int CPU_PRIO = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    lock_i,
    input  logic [N-1:0]    we_i,
    input  logic [N*AW-1:0] addr_i,
    input  logic [N*DW-1:0] wdata_i,
    output logic [N-1:0]    gnt_o,
    output logic [N-1:0]    rvalid_o,
    output logic [DW-1:0]   rdata_o,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy_o
);

    localparam int IW = clog2(N);
    localparam int HW = clog2(MAX_HOLD);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [N-1:0]  pick_gnt;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] next_ptr;
    logic          access;
    rd_tag_t       rd_pipe [RD_LAT];
    rd_tag_t       rd_tail;

    gpp16_rr_pick #(.N(N), .IW(IW)) u_pick (
        .req      (req_i),
        .ptr      (ptr_q),
        .cpu_prio (CPU_PRIO != 0),
        .gnt      (pick_gnt),
        .idx      (pick_idx)
    );

    assign next_ptr = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        access    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d = OWN;
                    owner_d = pick_idx;
                    gnt_d   = pick_gnt;
                    hold_d  = '0;
                end
            end
            OWN: begin
                if (req_i[owner_q]) begin
                    access    = 1'b1;
                    mem_en    = 1'b1;
                    mem_we    = we_i[owner_q];
                    mem_addr  = addr_i[owner_q*AW +: AW];
                    mem_wdata = wdata_i[owner_q*DW +: DW];
                end
                // Tenure ends on a dropped request, an unlocked access or a full burst.
                if (!req_i[owner_q] || !lock_i[owner_q] || hold_q == HW'(MAX_HOLD - 1)) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = next_ptr;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
        end
    end

    // Read ids ride alongside the memory latency so data returns to the issuer
    // even after the grant has moved to another master.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                rd_pipe[i] <= '0;
            end
        end else begin
            rd_pipe[0] <= '{valid: access & ~mem_we, id: TAG_IDW'(owner_q)};
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign rd_tail = rd_pipe[RD_LAT-1];

    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        if (rd_tail.valid) begin
            rvalid_o = N'(1) << rd_tail.id;
            rdata_o  = mem_rdata;
        end
    end

    assign gnt_o  = gnt_q;
    assign busy_o = (state_q == OWN);

endmodule

// File: tb/tb_gpp16_mem_arbiter.sv
// Directed bench for gpp16_mem_arbiter: dut_a uses defaults (RD_LAT=1, no CPU priority),
// dut_b uses RD_LAT=2 with CPU priority; both share the master-side stimulus.
module tb_gpp16_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, lock, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0]   mem_rdata;

    logic [N-1:0]  gnt_a, rvalid_a, gnt_b, rvalid_b;
    logic [DW-1:0] rdata_a, rdata_b, mem_wdata_a, mem_wdata_b;
    logic [AW-1:0] mem_addr_a, mem_addr_b;
    logic          mem_en_a, mem_we_a, busy_a, mem_en_b, mem_we_b, busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gpp16_mem_arbiter #(.N(N), .AW(AW), .DW(DW), .RD_LAT(1), .MAX_HOLD(8), .CPU_PRIO(0)) dut_a (
        .clk(clk), .rst(rst), .req_i(req), .lock_i(lock), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(gnt_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_rdata(mem_rdata), .busy_o(busy_a)
    );

    gpp16_mem_arbiter #(.N(N), .AW(AW), .DW(DW), .RD_LAT(2), .MAX_HOLD(8), .CPU_PRIO(1)) dut_b (
        .clk(clk), .rst(rst), .req_i(req), .lock_i(lock), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata), .busy_o(busy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive(input int k, input logic r, input logic l, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[k]            = r;
        lock[k]           = l;
        we[k]             = w;
        addr[k*AW +: AW]  = a;
        wdata[k*DW +: DW] = d;
    endtask

    task automatic do_reset();
        cyc();
        rst   = 1'b1;
        req   = '0;
        lock  = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0]  rr_exp [8];
        logic [N-1:0]  burst_exp [12];
        logic [AW-1:0] exp_addr;
        int acc, rv;

        rr_exp    = '{4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000};
        burst_exp = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                      4'b0000, 4'b0100, 4'b0100, 4'b0000};

        // Reset state
        rst = 1'b1; req = '0; lock = '0; we = '0; addr = '0; wdata = '0; mem_rdata = 16'h9999;
        repeat (2) cyc();
        #1;
        check_eq("rst_gnt", gnt_a, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_mem_en", mem_en_a, 0);
        check_eq("rst_mem_addr", mem_addr_a, 0);
        check_eq("rst_rvalid", rvalid_a, 0);
        check_eq("rst_rdata", rdata_a, 0);
        rst = 1'b0;

        // Single read, RD_LAT=1
        cyc(); drive(1, 1, 0, 0, 16'h0040, 16'h0); mem_rdata = 16'hBEEF; #1;
        check_eq("rd_gnt_t0", gnt_a, 0);
        cyc(); #1;
        check_eq("rd_gnt_t1", gnt_a, 4'b0010);
        check_eq("rd_mem_en_t1", mem_en_a, 1);
        check_eq("rd_mem_we_t1", mem_we_a, 0);
        check_eq("rd_mem_addr_t1", mem_addr_a, 16'h0040);
        check_eq("rd_busy_t1", busy_a, 1);
        check_eq("rd_rvalid_t1", rvalid_a, 0);
        cyc(); drive(1, 0, 0, 0, 16'h0, 16'h0); #1;
        check_eq("rd_rvalid_t2", rvalid_a, 4'b0010);
        check_eq("rd_rdata_t2", rdata_a, 16'hBEEF);
        check_eq("rd_gnt_t2", gnt_a, 0);

        // Round-robin between masters 1 and 2, ptr starts at 0
        do_reset();
        cyc();
        drive(1, 1, 0, 0, 16'h0100, 16'h0);
        drive(2, 1, 0, 0, 16'h0200, 16'h0);
        mem_rdata = 16'h5A5A;
        #1;
        check_eq("rr_gnt_pre", gnt_a, 0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i == 7) req = '0;
            #1;
            exp_addr = (rr_exp[i] == 4'b0010) ? 16'h0100 : (rr_exp[i] == 4'b0100) ? 16'h0200 : 16'h0;
            check_eq($sformatf("rr_gnt_%0d", i), gnt_a, rr_exp[i]);
            check_eq($sformatf("rr_mem_en_%0d", i), mem_en_a, rr_exp[i] != 0);
            check_eq($sformatf("rr_mem_addr_%0d", i), mem_addr_a, exp_addr);
        end

        // Locked burst of 10 reads capped at 8 per tenure
        cyc(); drive(2, 1, 1, 0, 16'h0222, 16'h0); mem_rdata = 16'hC0DE; #1;
        acc = 0;
        rv  = 0;
        for (int i = 0; i < 13; i++) begin
            cyc();
            if (i == 10) lock[2] = 1'b0;
            if (i == 11) req[2] = 1'b0;
            #1;
            if (i < 12) check_eq($sformatf("burst_gnt_%0d", i), gnt_a, burst_exp[i]);
            if (mem_en_a) acc++;
            if (rvalid_a[2]) rv++;
        end
        check_eq("burst_accesses", acc, 10);
        check_eq("burst_rvalid", rv, 10);

        // Write from master 3
        cyc(); drive(3, 1, 0, 1, 16'h00FF, 16'h1234); #1;
        cyc(); #1;
        check_eq("wr_gnt", gnt_a, 4'b1000);
        check_eq("wr_mem_en", mem_en_a, 1);
        check_eq("wr_mem_we", mem_we_a, 1);
        check_eq("wr_mem_addr", mem_addr_a, 16'h00FF);
        check_eq("wr_mem_wdata", mem_wdata_a, 16'h1234);
        cyc(); drive(3, 0, 0, 0, 16'h0, 16'h0); #1;
        check_eq("wr_rvalid_1", rvalid_a, 0);
        check_eq("wr_rdata_1", rdata_a, 0);
        cyc(); #1;
        check_eq("wr_rvalid_2", rvalid_a, 0);

        // CPU priority with ptr=3 (dut_b), plain round-robin comparison (dut_a)
        do_reset();
        cyc(); drive(2, 1, 0, 0, 16'h0020, 16'h0); mem_rdata = 16'h7777;
        cyc();
        cyc();
        drive(2, 0, 0, 0, 16'h0, 16'h0);
        drive(0, 1, 0, 0, 16'h0010, 16'h0);
        drive(3, 1, 0, 0, 16'h0030, 16'h0);
        #1;
        cyc(); #1;
        check_eq("prio_gnt_b_first", gnt_b, 4'b0001);
        check_eq("prio_mem_addr_b", mem_addr_b, 16'h0010);
        check_eq("prio_gnt_a_rr", gnt_a, 4'b1000);
        cyc(); drive(0, 0, 0, 0, 16'h0, 16'h0); #1;
        check_eq("prio_gnt_b_idle", gnt_b, 0);
        check_eq("prio_rvalid_b_lat1", rvalid_b, 0);
        cyc(); #1;
        check_eq("prio_gnt_b_second", gnt_b, 4'b1000);
        check_eq("prio_rvalid_b_m0", rvalid_b, 4'b0001);
        check_eq("prio_rdata_b_m0", rdata_b, 16'h7777);
        cyc(); drive(3, 0, 0, 0, 16'h0, 16'h0); #1;
        check_eq("prio_rvalid_b_gap", rvalid_b, 0);
        cyc(); #1;
        check_eq("prio_rvalid_b_m3", rvalid_b, 4'b1000);

        // Reset during an in-flight read, RD_LAT=2 (dut_b)
        do_reset();
        cyc(); drive(1, 1, 0, 0, 16'h0011, 16'h0); mem_rdata = 16'hABCD; #1;
        cyc(); #1;
        check_eq("mid_gnt_b", gnt_b, 4'b0010);
        check_eq("mid_mem_en_b", mem_en_b, 1);
        cyc(); rst = 1'b1; drive(1, 0, 0, 0, 16'h0, 16'h0); #1;
        check_eq("mid_rvalid_b_0", rvalid_b, 0);
        cyc(); #1;
        check_eq("mid_rst_gnt_b", gnt_b, 0);
        check_eq("mid_rst_rvalid_b", rvalid_b, 0);
        check_eq("mid_rst_rdata_b", rdata_b, 0);
        check_eq("mid_rst_mem_en_b", mem_en_b, 0);
        check_eq("mid_rst_busy_b", busy_b, 0);
        rst = 1'b0;
        cyc(); drive(1, 1, 0, 0, 16'h0011, 16'h0); #1;
        check_eq("mid_rvalid_b_dropped", rvalid_b, 0);
        cyc(); #1;
        check_eq("mid_regrant_b", gnt_b, 4'b0010);
        cyc(); drive(1, 0, 0, 0, 16'h0, 16'h0); #1;
        check_eq("mid_rvalid_b_wait", rvalid_b, 0);
        cyc(); #1;
        check_eq("mid_rvalid_b_fresh", rvalid_b, 4'b0010);
        check_eq("mid_rdata_b_fresh", rdata_b, 16'hABCD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
